// File: rtl/envelope_shaper.sv
// ADSR envelope generator that scales the oscillator's square output.
// The envelope steps once per prescaler tick; gate edges act on every clock.
module envelope_shaper #(
  parameter int TICK_DIV = 256,
  parameter int ENV_MAX  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gate,
  input  logic [7:0] square_in,
  input  logic [7:0] attack_rate,
  input  logic [7:0] decay_rate,
  input  logic [7:0] sustain_level,
  input  logic [7:0] release_rate,
  output logic [7:0] sample_out,
  output logic [7:0] env_level,
  output logic [2:0] state_out,
  output logic       busy
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [7:0] ENV_TOP = 8'(ENV_MAX);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    env_q, env_d;
  logic [7:0]    sample_q, sample_d;
  logic          gate_q;
  logic          busy_q;
  logic          tick, rise, fall;
  logic [8:0]    sum9, dec9, rel9;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;
  assign rise  = gate & ~gate_q;
  assign fall  = ~gate & gate_q;

  // 9-bit arithmetic so the carry/borrow reveals saturation and underflow
  assign sum9 = {1'b0, env_q} + {1'b0, attack_rate};
  assign dec9 = {1'b0, env_q} - {1'b0, decay_rate};
  assign rel9 = {1'b0, env_q} - {1'b0, release_rate};

  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (rise) begin
      state_d = ATTACK;
    end else if (fall) begin
      if (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)
        state_d = RELEASE;
    end else if (tick) begin
      case (state_q)
        ATTACK: begin
          if (attack_rate == 8'd0 || sum9 >= {1'b0, ENV_TOP}) begin
            env_d   = ENV_TOP;
            state_d = DECAY;
          end else begin
            env_d = sum9[7:0];
          end
        end
        DECAY: begin
          if (decay_rate == 8'd0 || dec9[8] || dec9[7:0] <= sustain_level) begin
            env_d   = sustain_level;
            state_d = SUSTAIN;
          end else begin
            env_d = dec9[7:0];
          end
        end
        SUSTAIN: env_d = sustain_level;
        RELEASE: begin
          if (release_rate == 8'd0 || rel9[8] || rel9[7:0] == 8'd0) begin
            env_d   = 8'd0;
            state_d = IDLE;
          end else begin
            env_d = rel9[7:0];
          end
        end
        IDLE:    env_d = 8'd0;
        default: begin
          env_d   = 8'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // Top byte of the 16-bit product; full scale 255*255 lands on 254
  assign sample_d = 8'(({8'd0, square_in} * {8'd0, env_q}) >> 8);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      env_q    <= 8'd0;
      sample_q <= 8'd0;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      env_q    <= env_d;
      sample_q <= sample_d;
      gate_q   <= gate;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign sample_out = sample_q;
  assign env_level  = env_q;
  assign state_out  = state_q;
  assign busy       = busy_q;

endmodule
